// File: rtl/reg_two_read.sv
// Data register with two independent valid/ready read ports.
// Each read port tracks an unread value and counts values overwritten before they were read.
`timescale 1ns/1ps

module reg_two_read_port #(
    parameter int unsigned ovr_width = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en_i,
    input  logic                 rdy_i,
    input  logic                 clr_ovr_i,
    output logic                 valid_o,
    output logic [ovr_width-1:0] ovr_o
);

    localparam logic [ovr_width-1:0] OVR_MAX = '1;

    logic                 valid_q, valid_d;
    logic [ovr_width-1:0] ovr_q, ovr_d;
    logic                 fire;

    assign fire = valid_q & rdy_i;

    // A write always leaves a pending value; a write into an unread slot is an overrun.
    always_comb begin
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (wr_en_i) begin
            valid_d = 1'b1;
        end else if (fire) begin
            valid_d = 1'b0;
        end
        if (clr_ovr_i) begin
            ovr_d = '0;
        end else if (wr_en_i && valid_q && !fire && ovr_q != OVR_MAX) begin
            ovr_d = ovr_q + ovr_width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ovr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign valid_o = valid_q;
    assign ovr_o   = ovr_q;

endmodule

module reg_two_read #(
    parameter int unsigned         width     = 1,
    parameter logic [width-1:0]    init      = '0,
    parameter int unsigned         ovr_width = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [width-1:0]     D_IN,
    input  logic                 EN,
    output logic [width-1:0]     Q_OUT,
    output logic                 VALID_A,
    input  logic                 RDY_A,
    output logic [width-1:0]     DATA_A,
    output logic [ovr_width-1:0] OVR_A,
    output logic                 VALID_B,
    input  logic                 RDY_B,
    output logic [width-1:0]     DATA_B,
    output logic [ovr_width-1:0] OVR_B,
    input  logic                 CLR_OVR
);

    logic [width-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (EN) begin
            q_d = D_IN;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q_q <= init;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q_OUT  = q_q;
    assign DATA_A = q_q;
    assign DATA_B = q_q;

    reg_two_read_port #(
        .ovr_width (ovr_width)
    ) u_port_a (
        .clk       (CLK),
        .rst_n     (RST),
        .wr_en_i   (EN),
        .rdy_i     (RDY_A),
        .clr_ovr_i (CLR_OVR),
        .valid_o   (VALID_A),
        .ovr_o     (OVR_A)
    );

    reg_two_read_port #(
        .ovr_width (ovr_width)
    ) u_port_b (
        .clk       (CLK),
        .rst_n     (RST),
        .wr_en_i   (EN),
        .rdy_i     (RDY_B),
        .clr_ovr_i (CLR_OVR),
        .valid_o   (VALID_B),
        .ovr_o     (OVR_B)
    );

endmodule

// File: tb/tb_reg_two_read.sv
// Bench for reg_two_read: directed scenarios plus random traffic against a behavioural model.
`timescale 1ns/1ps

module tb_reg_two_read;

    localparam int unsigned W   = 8;
    localparam int unsigned OW  = 8;
    localparam logic [W-1:0] INIT = 8'h00;
    localparam int OVR_SAT = 255;

    logic          CLK;
    logic          RST;
    logic [W-1:0]  D_IN;
    logic          EN;
    logic [W-1:0]  Q_OUT;
    logic          VALID_A, RDY_A, VALID_B, RDY_B, CLR_OVR;
    logic [W-1:0]  DATA_A, DATA_B;
    logic [OW-1:0] OVR_A, OVR_B;

    int errs;
    int checks;

    // behavioural model state
    int m_q;
    bit m_va, m_vb;
    int m_oa, m_ob;

    reg_two_read #(
        .width     (W),
        .init      (INIT),
        .ovr_width (OW)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .D_IN    (D_IN),
        .EN      (EN),
        .Q_OUT   (Q_OUT),
        .VALID_A (VALID_A),
        .RDY_A   (RDY_A),
        .DATA_A  (DATA_A),
        .OVR_A   (OVR_A),
        .VALID_B (VALID_B),
        .RDY_B   (RDY_B),
        .DATA_B  (DATA_B),
        .OVR_B   (OVR_B),
        .CLR_OVR (CLR_OVR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q  = int'(INIT);
        m_va = 1'b0;
        m_vb = 1'b0;
        m_oa = 0;
        m_ob = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},   32'(Q_OUT),   32'(m_q));
        check({tag, ".da"},  32'(DATA_A),  32'(m_q));
        check({tag, ".db"},  32'(DATA_B),  32'(m_q));
        check({tag, ".va"},  32'(VALID_A), 32'(m_va));
        check({tag, ".vb"},  32'(VALID_B), 32'(m_vb));
        check({tag, ".oa"},  32'(OVR_A),   32'(m_oa));
        check({tag, ".ob"},  32'(OVR_B),   32'(m_ob));
    endtask

    // One read port: a write marks a value pending; a write over an unread value counts an overrun.
    task automatic port_next(inout bit v, inout int o, input bit rdy);
        bit consumed;
        bit overwritten;
        consumed    = v && rdy;
        overwritten = EN && v && !consumed;
        if (CLR_OVR)          o = 0;
        else if (overwritten) o = (o + 1 > OVR_SAT) ? OVR_SAT : o + 1;
        v = EN ? 1'b1 : (consumed ? 1'b0 : v);
    endtask

    task automatic drive(input bit en, input int d, input bit ra, input bit rb, input bit clr);
        EN      = en;
        D_IN    = W'(d);
        RDY_A   = ra;
        RDY_B   = rb;
        CLR_OVR = clr;
    endtask

    // Compare mid-cycle, advance the model with the applied inputs, then step past the edge.
    task automatic step(input string tag);
        @(negedge CLK);
        check_all(tag);
        if (!RST) begin
            model_reset();
        end else begin
            port_next(m_va, m_oa, RDY_A);
            port_next(m_vb, m_ob, RDY_B);
            if (EN) m_q = int'(D_IN);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        RST    = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        #2;
        check_all("reset");
        @(posedge CLK);
        #1;
        RST = 1'b1;

        // first write sets both ports valid
        drive(1, 8'h5A, 0, 0, 0);
        step("wr5a");
        check("wr5a_q",  32'(Q_OUT),   32'h5A);
        check("wr5a_va", 32'(VALID_A), 32'd1);
        check("wr5a_vb", 32'(VALID_B), 32'd1);
        drive(0, 0, 1, 0, 0);
        check("fire_a_data", 32'(DATA_A), 32'h5A);
        step("fire_a");
        check("fire_a_va", 32'(VALID_A), 32'd0);
        check("fire_a_vb", 32'(VALID_B), 32'd1);

        // fire coinciding with a write returns the old value and keeps valid
        drive(1, 8'h22, 0, 0, 0);
        step("wr22");
        drive(1, 8'h11, 1, 0, 0);
        check("fire_wr_old", 32'(DATA_A), 32'h22);
        step("fire_wr");
        check("fire_wr_va", 32'(VALID_A), 32'd1);
        check("fire_wr_q",  32'(Q_OUT),   32'h11);
        check("fire_wr_oa", 32'(OVR_A),   32'd0);

        // drain B and clear counters, then overrun B
        drive(0, 0, 0, 1, 1);
        step("drain_b");
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h30 + i, 1, 0, 0);
            step("ovr_b3");
        end
        check("ovr_b_two",   32'(OVR_B),   32'd2);
        check("ovr_b_valid", 32'(VALID_B), 32'd1);
        for (int i = 0; i < 300; i++) begin
            drive(1, int'($urandom_range(0, 255)), 1, 0, 0);
            step("ovr_b_sat");
        end
        check("ovr_b_255", 32'(OVR_B), 32'd255);

        // clear beats a simultaneous overrun increment
        drive(1, 8'h77, 0, 0, 1);
        step("clr_win");
        check("clr_oa", 32'(OVR_A), 32'd0);
        check("clr_ob", 32'(OVR_B), 32'd0);
        check("clr_q",  32'(Q_OUT), 32'h77);

        // build OVR_A=5 then pulse reset between edges
        for (int i = 0; i < 5; i++) begin
            drive(1, int'($urandom_range(1, 255)), 0, 1, 0);
            step("ovr_a5");
        end
        check("ovr_a_five", 32'(OVR_A),   32'd5);
        check("ovr_a_va",   32'(VALID_A), 32'd1);
        drive(0, 0, 0, 0, 0);
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        check("async_q",  32'(Q_OUT),   32'(INIT));
        check("async_va", 32'(VALID_A), 32'd0);
        check("async_oa", 32'(OVR_A),   32'd0);
        check("async_ob", 32'(OVR_B),   32'd0);
        drive(1, 8'hAB, 1, 1, 1);
        step("rst_hold");
        check("rst_hold_q", 32'(Q_OUT), 32'(INIT));
        RST = 1'b1;
        drive(1, 8'h3C, 0, 0, 0);
        step("post_rst");
        check("post_rst_va", 32'(VALID_A), 32'd1);
        check("post_rst_oa", 32'(OVR_A),   32'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                  int'($urandom_range(0, 255)),
                  ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 3)  ? 1'b1 : 1'b0);
            step("rand");
        end
        drive(0, 0, 0, 0, 0);
        step("final");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
